// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared types and constants for the memory arbiter: FSM state encoding,
//   load/store size codes, bus widths and the size-to-byte-count helper.
package mem_arbiter_pkg;

  localparam int Instruction_Address_size = 32;
  localparam int Instruction_size         = 32;
  localparam int DATA_W                   = 32;
  localparam int BYTE_W                   = 8;
  localparam int CNT_W                    = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INST  = 3'd1,
    LOAD  = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } arb_state_t;

  typedef enum logic [1:0] {
    SIZE_BYTE     = 2'd0,
    SIZE_HALF     = 2'd1,
    SIZE_WORD     = 2'd2,
    SIZE_WORD_ALT = 2'd3
  } size_t;

  localparam logic [CNT_W-1:0] INST_BYTES = 3'd4;

  // Size code 3 is treated as a full word.
  function automatic logic [CNT_W-1:0] size_to_bytes(input logic [1:0] size);
    logic [CNT_W-1:0] n;
    case (size)
      2'd0:    n = 3'd1;
      2'd1:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the instruction-fetch port, the load/store port and the byte-wide
//   RAM port of the arbiter.
//   slave  : used by the arbiter (takes requests and ram_din, drives results
//            and the RAM address/write strobe).
//   master : used by the requesters / RAM model on the other side.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic                                inst_read_flag;
  logic [Instruction_Address_size-1:0] inst_read_address;
  logic                                inst_flag;
  logic [Instruction_size-1:0]         inst;

  logic                                data_read_flag;
  logic                                data_write_flag;
  logic [DATA_W-1:0]                   data_address;
  logic [1:0]                          data_size;
  logic [DATA_W-1:0]                   data_write;
  logic                                data_flag;
  logic [DATA_W-1:0]                   data_read;

  logic [BYTE_W-1:0]                   ram_din;
  logic [BYTE_W-1:0]                   ram_dout;
  logic [DATA_W-1:0]                   ram_a;
  logic                                ram_wr;

  modport slave (
    input  inst_read_flag, inst_read_address,
    input  data_read_flag, data_write_flag, data_address, data_size, data_write,
    input  ram_din,
    output inst_flag, inst, data_flag, data_read,
    output ram_dout, ram_a, ram_wr
  );

  modport master (
    output inst_read_flag, inst_read_address,
    output data_read_flag, data_write_flag, data_address, data_size, data_write,
    output ram_din,
    input  inst_flag, inst, data_flag, data_read,
    input  ram_dout, ram_a, ram_wr
  );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Serialises instruction fetches and data loads/stores onto a byte-wide
//   synchronous RAM. Data requests win over a pending fetch. Reads issue one
//   byte address per cycle and capture each byte two edges after its address
//   was presented; stores write one byte per cycle. Completion is a one-cycle
//   inst_flag/data_flag pulse in the DONE state; results hold between pulses.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - synchronous active-high reset
//     bus  - mem_arbiter_if.slave (fetch, load/store and RAM signals)
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [Instruction_size-1:0] inst_q, inst_d;
  logic [DATA_W-1:0] data_read_q, data_read_d;
  logic              is_inst_q, is_inst_d;

  // n counts addresses issued; the byte arriving now belongs to address n-1.
  logic [1:0]        cap_idx;
  logic [DATA_W-1:0] asm_capt;

  always_comb begin
    cap_idx  = n_q[1:0] - 2'd1;
    asm_capt = asm_q;
    asm_capt[{cap_idx, 3'b000} +: BYTE_W] = bus.ram_din;
  end

  // ---- next state / datapath loads ----
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    len_d       = len_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    inst_d      = inst_q;
    data_read_d = data_read_q;
    is_inst_d   = is_inst_q;

    case (state_q)
      IDLE: begin
        if (bus.data_read_flag || bus.data_write_flag) begin
          addr_d    = bus.data_address;
          len_d     = size_to_bytes(bus.data_size);
          wdata_d   = bus.data_write;
          asm_d     = '0;
          n_d       = '0;
          is_inst_d = 1'b0;
          state_d   = bus.data_write_flag ? STORE : LOAD;
        end else if (bus.inst_read_flag) begin
          addr_d    = bus.inst_read_address;
          len_d     = INST_BYTES;
          asm_d     = '0;
          n_d       = '0;
          is_inst_d = 1'b1;
          state_d   = INST;
        end
      end

      INST, LOAD: begin
        if (state_q == INST && !bus.inst_read_flag) begin
          // Fetch withdrawn: drop everything captured so far.
          state_d = IDLE;
          n_d     = '0;
        end else begin
          if (n_q != '0) asm_d = asm_capt;
          if (n_q == len_q) begin
            state_d = DONE;
            n_d     = '0;
            if (state_q == INST) inst_d = asm_capt;
            else                 data_read_d = asm_capt;
          end else begin
            n_d = n_q + 3'd1;
          end
        end
      end

      STORE: begin
        if (n_q == len_q - 3'd1) begin
          state_d = DONE;
          n_d     = '0;
        end else begin
          n_d = n_q + 3'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        n_d     = '0;
      end
    endcase
  end

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      n_q         <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      asm_q       <= '0;
      inst_q      <= '0;
      data_read_q <= '0;
      is_inst_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      inst_q      <= inst_d;
      data_read_q <= data_read_d;
      is_inst_q   <= is_inst_d;
    end
  end

  // ---- outputs ----
  assign bus.ram_a     = addr_q + {{(DATA_W-CNT_W){1'b0}}, n_q};
  assign bus.ram_wr    = (state_q == STORE);
  assign bus.ram_dout  = (state_q == STORE) ? wdata_q[{n_q[1:0], 3'b000} +: BYTE_W] : '0;
  assign bus.inst_flag = (state_q == DONE) &&  is_inst_q;
  assign bus.data_flag = (state_q == DONE) && !is_inst_q;
  assign bus.inst      = inst_q;
  assign bus.data_read = data_read_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  mem_arbiter_if bus();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte-wide synchronous RAM model: read data appears after the edge that
  // sampled the address; writes land at the edge.
  logic [7:0] mem [0:4095];
  always @(posedge clk) begin
    bus.ram_din <= mem[bus.ram_a[11:0]];
    if (bus.ram_wr) mem[bus.ram_a[11:0]] = bus.ram_dout;
  end

  typedef struct {
    bit          is_inst;
    bit          chk_val;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  typedef struct {
    int          op;     // 0 fetch, 1 load, 2 store
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          lat;    // cycle (1-based after accepting edge) of the flag
  } vec_t;

  exp_t sb[$];
  wr_t  wlog[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    if (s == 2'd0) return 1;
    if (s == 2'd1) return 2;
    return 4;
  endfunction

  // Scoreboard side: every flag pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.inst_flag || bus.data_flag) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_flag: inst_flag=%0b data_flag=%0b with no request outstanding",
                 bus.inst_flag, bus.data_flag);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("flag_kind", {31'b0, bus.inst_flag}, {31'b0, e.is_inst});
        chk("one_flag", {31'b0, bus.inst_flag & bus.data_flag}, 32'd0);
        if (e.chk_val) chk("result", e.is_inst ? bus.inst : bus.data_read, e.val);
        chk("latency_cycle", 32'(cyc), 32'(e.cyc));
      end
      done_cnt++;
    end
    if (bus.ram_wr) wlog.push_back('{bus.ram_a, bus.ram_dout});
  end

  task automatic clear_req();
    bus.inst_read_flag    = 1'b0;
    bus.inst_read_address = '0;
    bus.data_read_flag    = 1'b0;
    bus.data_write_flag   = 1'b0;
    bus.data_address      = '0;
    bus.data_size         = '0;
    bus.data_write        = '0;
  endtask

  task automatic wait_done(input string name);
    int  start;
    bit  got;
    start = done_cnt;
    got   = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != start) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no completion flag within 30 cycles, required one", name);
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int n;
    wlog.delete();
    @(negedge clk);
    case (v.op)
      0: begin
        bus.inst_read_flag    = 1'b1;
        bus.inst_read_address = v.addr;
      end
      1: begin
        bus.data_read_flag = 1'b1;
        bus.data_address   = v.addr;
        bus.data_size      = v.size;
      end
      default: begin
        bus.data_write_flag = 1'b1;
        bus.data_address    = v.addr;
        bus.data_size       = v.size;
        bus.data_write      = v.wdata;
      end
    endcase
    sb.push_back('{(v.op == 0), (v.op != 2), v.exp, cyc + v.lat});
    wait_done(name);
    clear_req();
    if (v.op == 2) begin
      n = nbytes(v.size);
      chk({name, "_wr_count"}, 32'(wlog.size()), 32'(n));
      for (int k = 0; k < n && k < wlog.size(); k++) begin
        chk({name, "_wr_addr"}, wlog[k].a, v.addr + 32'(k));
        chk({name, "_wr_byte"}, {24'b0, wlog[k].d}, {24'b0, v.wdata[8*k +: 8]});
      end
    end else begin
      chk({name, "_no_writes"}, 32'(wlog.size()), 32'd0);
    end
  endtask

  vec_t vecs [11];

  initial begin
    int a;
    vecs[0]  = '{0, 2'd2, 32'h0000_0004, 32'h0,          32'h0000_0013, 6};
    vecs[1]  = '{1, 2'd2, 32'h0000_0100, 32'h0,          32'h1122_3344, 6};
    vecs[2]  = '{1, 2'd1, 32'h0000_0102, 32'h0,          32'h0000_1122, 4};
    vecs[3]  = '{1, 2'd0, 32'h0000_0200, 32'h0,          32'h0000_0080, 3};
    vecs[4]  = '{2, 2'd2, 32'h0000_0300, 32'hDEAD_BEEF,  32'h0,         5};
    vecs[5]  = '{1, 2'd2, 32'h0000_0300, 32'h0,          32'hDEAD_BEEF, 6};
    vecs[6]  = '{2, 2'd0, 32'h0000_0310, 32'h1234_56AB,  32'h0,         2};
    vecs[7]  = '{1, 2'd3, 32'h0000_0310, 32'h0,          32'h0000_00AB, 6};
    vecs[8]  = '{2, 2'd1, 32'h0000_0101, 32'h0000_BEEF,  32'h0,         3};
    vecs[9]  = '{1, 2'd2, 32'h0000_0100, 32'h0,          32'h11BE_EF44, 6};
    vecs[10] = '{1, 2'd2, 32'hFFFF_FFFE, 32'h0,          32'hD4C3_B2A1, 6};

    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h004] = 8'h13;
    mem[12'h100] = 8'h44; mem[12'h101] = 8'h33; mem[12'h102] = 8'h22; mem[12'h103] = 8'h11;
    mem[12'h200] = 8'h80;
    mem[12'hFFE] = 8'hA1; mem[12'hFFF] = 8'hB2; mem[12'h000] = 8'hC3; mem[12'h001] = 8'hD4;

    clear_req();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_inst_flag", {31'b0, bus.inst_flag}, 32'd0);
    chk("rst_data_flag", {31'b0, bus.data_flag}, 32'd0);
    chk("rst_ram_wr",    {31'b0, bus.ram_wr},    32'd0);
    chk("rst_ram_a",     bus.ram_a,              32'd0);
    chk("rst_ram_dout",  {24'b0, bus.ram_dout},  32'd0);
    chk("rst_inst",      bus.inst,               32'd0);
    chk("rst_data_read", bus.data_read,          32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Simultaneous fetch and word load: load is served first, then the fetch.
    @(negedge clk);
    bus.inst_read_flag    = 1'b1;
    bus.inst_read_address = 32'h4;
    bus.data_read_flag    = 1'b1;
    bus.data_address      = 32'h100;
    bus.data_size         = 2'd2;
    a = cyc + 1;
    sb.push_back('{1'b0, 1'b1, 32'h11BE_EF44, a + 5});
    sb.push_back('{1'b1, 1'b1, 32'h0000_0013, a + 12});
    wait_done("prio_load");
    bus.data_read_flag = 1'b0;
    wait_done("prio_fetch");
    clear_req();

    // Fetch withdrawn after two cycles; a byte load then starts at once.
    wlog.delete();
    @(negedge clk);
    bus.inst_read_flag    = 1'b1;
    bus.inst_read_address = 32'h4;
    a = cyc + 1;
    @(negedge clk);
    @(negedge clk);
    bus.inst_read_flag = 1'b0;
    bus.data_read_flag = 1'b1;
    bus.data_address   = 32'h200;
    bus.data_size      = 2'd0;
    sb.push_back('{1'b0, 1'b1, 32'h0000_0080, a + 5});
    wait_done("abort_load");
    clear_req();
    chk("abort_no_writes", 32'(wlog.size()), 32'd0);

    // Reset in the middle of a word store.
    wlog.delete();
    @(negedge clk);
    bus.data_write_flag = 1'b1;
    bus.data_address    = 32'h400;
    bus.data_size       = 2'd2;
    bus.data_write      = 32'h4433_2211;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ram_wr",    {31'b0, bus.ram_wr},    32'd0);
    chk("mid_rst_ram_a",     bus.ram_a,              32'd0);
    chk("mid_rst_ram_dout",  {24'b0, bus.ram_dout},  32'd0);
    chk("mid_rst_data_flag", {31'b0, bus.data_flag}, 32'd0);
    chk("mid_rst_data_read", bus.data_read,          32'd0);
    chk("mid_rst_inst",      bus.inst,               32'd0);
    clear_req();
    rst = 1'b0;
    chk("mid_rst_wr_count", 32'(wlog.size()), 32'd2);
    chk("mid_rst_mem400",   {24'b0, mem[12'h400]}, 32'h11);
    chk("mid_rst_mem401",   {24'b0, mem[12'h401]}, 32'h22);
    chk("mid_rst_mem402",   {24'b0, mem[12'h402]}, 32'h00);
    run_vec("post_rst_load", '{1, 2'd2, 32'h0000_0400, 32'h0, 32'h0000_2211, 6});

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
